// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the shared register-file write-back port.
// Three requesters (A = integer ALU, B = FPU, C = load unit) compete each cycle. The
// winner gets a combinational grant and mux select, and its data/rd are captured into a
// one-stage write-back buffer on the granted edge.
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   stall                       blocks every grant this cycle
//   req_a/b/c, data_a/b/c,      per-requester request, write data and destination register
//   rd_a/b/c
//   gnt_a/b/c, sel              combinational grants and mux select (00=A 01=B 10=C 11=none)
//   wb_en, wb_rd, wb_data       registered write-back enable, register and data
module wb_port_arbiter #(
  parameter int unsigned N  = 32,
  parameter int unsigned RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          req_c,
  input  logic [N-1:0]  data_a,
  input  logic [N-1:0]  data_b,
  input  logic [N-1:0]  data_c,
  input  logic [RW-1:0] rd_a,
  input  logic [RW-1:0] rd_b,
  input  logic [RW-1:0] rd_c,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          gnt_c,
  output logic [1:0]    sel,
  output logic          wb_en,
  output logic [RW-1:0] wb_rd,
  output logic [N-1:0]  wb_data
);

  // Requester encodings, shared by the priority pointer and the mux select.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  logic [1:0]    r_ptr;
  logic [1:0]    w_win;
  logic [1:0]    w_ptr_nxt;
  logic [N-1:0]  w_data;
  logic [RW-1:0] w_rd;

  // Winner: first asserted request in rotating scan order starting at the pointer.
  // Grants are forced off while reset is asserted, since reset is asynchronous.
  always_comb begin
    w_win = SEL_NONE;
    if (RST && !stall) begin
      case (r_ptr)
        SEL_B: begin
          if (req_b)      w_win = SEL_B;
          else if (req_c) w_win = SEL_C;
          else if (req_a) w_win = SEL_A;
        end
        SEL_C: begin
          if (req_c)      w_win = SEL_C;
          else if (req_a) w_win = SEL_A;
          else if (req_b) w_win = SEL_B;
        end
        default: begin
          if (req_a)      w_win = SEL_A;
          else if (req_b) w_win = SEL_B;
          else if (req_c) w_win = SEL_C;
        end
      endcase
    end
  end

  assign gnt_a = (w_win == SEL_A);
  assign gnt_b = (w_win == SEL_B);
  assign gnt_c = (w_win == SEL_C);
  assign sel   = w_win;

  // Write-back mux and pointer advance (winner + 1 mod 3).
  always_comb begin
    w_data    = '0;
    w_rd      = '0;
    w_ptr_nxt = SEL_A;
    case (w_win)
      SEL_A: begin
        w_data    = data_a;
        w_rd      = rd_a;
        w_ptr_nxt = SEL_B;
      end
      SEL_B: begin
        w_data    = data_b;
        w_rd      = rd_b;
        w_ptr_nxt = SEL_C;
      end
      SEL_C: begin
        w_data    = data_c;
        w_rd      = rd_c;
        w_ptr_nxt = SEL_A;
      end
      default: begin
        w_data    = '0;
        w_rd      = '0;
        w_ptr_nxt = SEL_A;
      end
    endcase
  end

  // Pointer and write-back buffer; a write to x0 completes but never enables the port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr   <= SEL_A;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (w_win != SEL_NONE) begin
      r_ptr   <= w_ptr_nxt;
      wb_en   <= (w_rd != '0);
      wb_rd   <= w_rd;
      wb_data <= w_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter. Each requester owns a queue of
// pending transfers; a reference model picks the expected winner, checks the combinational
// grant, and pushes the expected write-back buffer contents for comparison one edge later.
module tb_wb_port_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned RW = 5;

  typedef struct {
    logic [RW-1:0] rd;
    logic [N-1:0]  data;
  } txn_t;

  typedef struct {
    logic          en;
    logic [RW-1:0] rd;
    logic [N-1:0]  data;
  } wb_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          stall = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic [N-1:0]  data_a = '0, data_b = '0, data_c = '0;
  logic [RW-1:0] rd_a = '0, rd_b = '0, rd_c = '0;
  logic          gnt_a, gnt_b, gnt_c;
  logic [1:0]    sel;
  logic          wb_en;
  logic [RW-1:0] wb_rd;
  logic [N-1:0]  wb_data;

  wb_port_arbiter #(.N(N), .RW(RW)) u_dut (
    .CLK(CLK), .RST(RST), .stall(stall),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c), .sel(sel),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;

  txn_t rq[3][$];
  wb_t  exp_q[$];
  int   m_ptr;
  logic [RW-1:0] m_rd;
  logic [N-1:0]  m_data;
  logic m_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int who, input logic [RW-1:0] rd, input logic [N-1:0] data);
    txn_t t;
    t.rd = rd;
    t.data = data;
    rq[who].push_back(t);
  endtask

  // Asynchronous reset from mid-cycle: outputs must clear at once, without a clock edge.
  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_gnt", 64'({gnt_a, gnt_b, gnt_c}), 64'd0);
    chk("rst_sel", 64'(sel), 64'h3);
    m_ptr = 0;
    m_rd = '0;
    m_data = '0;
    exp_q.delete();
    @(posedge CLK);
    #3;
    RST = 1'b1;
  endtask

  // One arbitration cycle; with rst_mid the in-flight grant is aborted by reset.
  task automatic step(input bit rst_mid = 1'b0);
    int  w;
    wb_t e;
    stall = m_stall;
    req_a = rq[0].size() > 0;
    req_b = rq[1].size() > 0;
    req_c = rq[2].size() > 0;
    rd_a = req_a ? rq[0][0].rd : '0;
    data_a = req_a ? rq[0][0].data : '0;
    rd_b = req_b ? rq[1][0].rd : '0;
    data_b = req_b ? rq[1][0].data : '0;
    rd_c = req_c ? rq[2][0].rd : '0;
    data_c = req_c ? rq[2][0].data : '0;
    #1;
    w = 3;
    if (!m_stall)
      for (int i = 0; i < 3; i++)
        if (w == 3 && rq[(m_ptr + i) % 3].size() > 0) w = (m_ptr + i) % 3;
    chk("gnt_a", 64'(gnt_a), 64'(w == 0));
    chk("gnt_b", 64'(gnt_b), 64'(w == 1));
    chk("gnt_c", 64'(gnt_c), 64'(w == 2));
    chk("sel", 64'(sel), 64'(w));
    if (rst_mid) begin
      do_reset();
      return;
    end
    if (w != 3) begin
      m_rd = rq[w][0].rd;
      m_data = rq[w][0].data;
      e.en = (m_rd != '0);
      void'(rq[w].pop_front());
      m_ptr = (w + 1) % 3;
    end else begin
      e.en = 1'b0;
    end
    e.rd = m_rd;
    e.data = m_data;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wb_en", 64'(wb_en), 64'(e.en));
      chk("wb_rd", 64'(wb_rd), 64'(e.rd));
      chk("wb_data", 64'(wb_data), 64'(e.data));
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++)
      if (rq[0].size() + rq[1].size() + rq[2].size() > 0) step();
  endtask

  initial begin
    // 1: reset, single ALU request; the idle cycle after shows the buffer holding with wb_en=0.
    do_reset();
    push(0, 5'd5, 32'h1234);
    step();
    step();
    // A again: ptr is B now, A is still the only requester.
    push(0, 5'd7, 32'hA5A5_0001);
    step();

    // 2: all three held from reset, two transfers each: A,B,C,A,B,C.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push(0, 5'(1 + k), 32'h1000 + 32'(k));
      push(1, 5'(3 + k), 32'h2000 + 32'(k));
      push(2, 5'(5 + k), 32'h3000 + 32'(k));
    end
    drain(6);
    step();

    // 3: move ptr to C, then A and B both pending: A wins first, then B.
    push(1, 5'd9, 32'hBEEF);
    step();
    push(0, 5'd10, 32'hAAAA);
    push(1, 5'd11, 32'hBBBB);
    step();
    step();

    // 4: x0 write from B completes with wb_en=0; ptr moves on so C beats A next.
    push(1, 5'd0, 32'hFFFF);
    step();
    push(0, 5'd12, 32'h0A0A);
    push(2, 5'd13, 32'h0C0C);
    step();

    // 5: stall with C pending blocks grants; A left over too.
    push(2, 5'd14, 32'hC0DE);
    m_stall = 1'b1;
    step();
    step();
    m_stall = 1'b0;
    drain(4);

    // 6: get ptr to B, then reset while B is granted; afterwards A wins first.
    push(0, 5'd15, 32'h1111);
    step();
    push(0, 5'd16, 32'h2222);
    push(1, 5'd17, 32'h3333);
    step(1'b1);
    step();
    drain(4);

    // Random traffic with stalls and occasional x0 writes.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 3; r++)
        if (rq[r].size() < 3 && $urandom_range(0, 2) == 0)
          push(r, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 32'($urandom));
      m_stall = ($urandom_range(0, 7) == 0);
      step();
    end
    m_stall = 1'b0;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
